// File: rtl/sw_column_readout_ctrl.sv
// Column-end readout controller: queues L1As, drives the chain broadcast bus,
// drains each triggered event via unreadHit/read and frames it into an output FIFO.
module sw_column_readout_ctrl #(
  parameter int PEND_W     = 4,
  parameter int FIFO_AW    = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              L1A,
  input  logic [8:0]        L1ADelay,
  input  logic [38:0]       swData,
  input  logic              swUnreadHit,
  output logic              swRead,
  output logic [11:0]       swBCST,
  output logic [39:0]       outData,
  output logic              outValid,
  input  logic              outReady,
  output logic [PEND_W-1:0] pendingL1A,
  output logic              l1Overflow
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0]  LP_ROOM_MAX   = (FIFO_AW+1)'(DEPTH-2);
  localparam logic [2:0]        LP_SETTLE_END = 3'(SETTLE_CYC-1);
  localparam logic [PEND_W-1:0] LP_PEND_ONE   = PEND_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_READ, S_GAP, S_TRAILER
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_reset_q, r_l1a_q, r_load, r_read;
  logic [PEND_W-1:0]   r_pend;
  logic                r_ovf;
  logic [11:0]         r_evt_cnt;
  logic [8:0]          r_hit_cnt;
  logic                r_trunc;
  logic [2:0]          r_settle;

  logic [39:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]    r_count;
  logic [39:0]         r_out_data;
  logic                r_out_valid;

  logic                w_fifo_wr, w_pop, w_room2, w_dec;
  logic [39:0]         w_fifo_din;
  logic [FIFO_AW:0]    w_used;

  // The output register counts toward occupancy so the total depth stays DEPTH.
  assign w_used  = r_count + {{FIFO_AW{1'b0}}, r_out_valid};
  assign w_room2 = (w_used <= LP_ROOM_MAX);
  assign w_pop   = (r_count != '0) && (!r_out_valid || outReady);
  assign w_dec   = (r_state == S_LOAD);

  always_comb begin
    w_state_nxt = r_state;
    w_fifo_wr   = 1'b0;
    w_fifo_din  = '0;
    case (r_state)
      S_IDLE:    if ((r_pend != '0) && !swUnreadHit && w_room2) w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_fifo_wr   = 1'b1;
        w_fifo_din  = {2'b10, 26'd0, r_evt_cnt};
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE:  if (r_settle == 3'd0) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (!swUnreadHit)  w_state_nxt = S_TRAILER;
        else if (w_room2)  w_state_nxt = S_READ;
      end
      S_READ: begin
        w_fifo_wr   = 1'b1;
        w_fifo_din  = {1'b0, swData};
        w_state_nxt = S_GAP;
      end
      S_GAP:     w_state_nxt = S_CHECK;
      S_TRAILER: begin
        w_fifo_wr   = 1'b1;
        w_fifo_din  = {2'b11, 28'd0, r_trunc, r_hit_cnt};
        w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    r_reset_q <= reset;
    if (reset) begin
      r_state   <= S_IDLE;
      r_l1a_q   <= 1'b0;
      r_load    <= 1'b0;
      r_read    <= 1'b0;
      r_pend    <= '0;
      r_ovf     <= 1'b0;
      r_evt_cnt <= '0;
      r_hit_cnt <= '0;
      r_trunc   <= 1'b0;
      r_settle  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_l1a_q <= L1A;
      r_load  <= (w_state_nxt == S_LOAD);
      r_read  <= (w_state_nxt == S_READ);
      if (L1A && !w_dec) begin
        if (&r_pend) r_ovf  <= 1'b1;
        else         r_pend <= r_pend + LP_PEND_ONE;
      end else if (!L1A && w_dec) begin
        r_pend <= r_pend - LP_PEND_ONE;
      end
      if (r_state == S_LOAD) begin
        r_evt_cnt <= r_evt_cnt + 12'd1;
        r_hit_cnt <= '0;
        r_trunc   <= 1'b0;
        r_settle  <= LP_SETTLE_END;
      end
      if (r_state == S_SETTLE && r_settle != 3'd0) r_settle <= r_settle - 3'd1;
      if (r_state == S_READ) begin
        if (r_hit_cnt != 9'h1FF)  r_hit_cnt <= r_hit_cnt + 9'd1;
        if (r_hit_cnt >= 9'd510)  r_trunc   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fifo_wr) r_mem[r_wr_ptr] <= w_fifo_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop) begin
        r_out_data  <= r_mem[r_rd_ptr];
        r_rd_ptr    <= r_rd_ptr + FIFO_AW'(1);
        r_out_valid <= 1'b1;
      end else if (outReady) begin
        r_out_valid <= 1'b0;
      end
      case ({w_fifo_wr, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign swRead     = r_read;
  assign swBCST     = {r_load, r_l1a_q, r_reset_q, L1ADelay};
  assign outData    = r_out_data;
  assign outValid   = r_out_valid;
  assign pendingL1A = r_pend;
  assign l1Overflow = r_ovf;

endmodule

// File: tb/tb_sw_column_readout_ctrl.sv
// Bench for sw_column_readout_ctrl: chain model, word scoreboard, vector table,
// directed corner sequences and randomized events.
module tb_sw_column_readout_ctrl;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset, L1A, swUnreadHit, swRead, outValid, outReady, l1Overflow;
  logic [8:0]  L1ADelay;
  logic [38:0] swData;
  logic [11:0] swBCST;
  logic [39:0] outData;
  logic [3:0]  pendingL1A;

  sw_column_readout_ctrl #(.PEND_W(4), .FIFO_AW(4), .SETTLE_CYC(2)) dut (
    .clk(clk), .reset(reset), .L1A(L1A), .L1ADelay(L1ADelay), .swData(swData),
    .swUnreadHit(swUnreadHit), .swRead(swRead), .swBCST(swBCST), .outData(outData),
    .outValid(outValid), .outReady(outReady), .pendingL1A(pendingL1A),
    .l1Overflow(l1Overflow)
  );

  always #12 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // chain model: events waiting for a load, and the hits of the loaded event
  logic [38:0] cur_q[$];
  logic [38:0] ev_hits[$];
  int          ev_n[$];
  bit          block = 0;
  logic [39:0] exp_q[$];
  logic [11:0] evt_model = 12'd0;
  int          events_sent = 0, trailers_seen = 0, words_seen = 0, hdr_zero = 0;
  logic [39:0] last_trailer = '0;

  task automatic upd_chain();
    swUnreadHit = (cur_q.size() != 0) || block;
    swData      = (cur_q.size() != 0) ? cur_q[0] : 39'd0;
  endtask

  bit s_read, s_load;
  always begin
    @(negedge clk);
    s_read = swRead;
    s_load = swBCST[11];
    @(posedge clk);
    #1;
    if (s_read && cur_q.size() > 0) void'(cur_q.pop_front());
    if (s_load && ev_n.size() > 0) begin
      int n;
      n = ev_n.pop_front();
      repeat (n) cur_q.push_back(ev_hits.pop_front());
    end
    upd_chain();
  end

  task automatic queue_event(int nhits);
    logic [63:0] r;
    logic [8:0]  hc;
    exp_q.push_back({2'b10, 26'd0, evt_model});
    evt_model = evt_model + 12'd1;
    ev_n.push_back(nhits);
    for (int i = 0; i < nhits; i++) begin
      r = {$urandom(), $urandom()};
      ev_hits.push_back(r[38:0]);
      exp_q.push_back({1'b0, r[38:0]});
    end
    hc = (nhits > 511) ? 9'd511 : 9'(nhits);
    exp_q.push_back({2'b11, 28'd0, (nhits >= 511) ? 1'b1 : 1'b0, hc});
    events_sent++;
  endtask

  task automatic send_l1a(int nhits);
    queue_event(nhits);
    L1A = 1'b1;
    @(posedge clk); #1;
    L1A = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); ev_n.delete(); ev_hits.delete(); cur_q.delete();
    evt_model = 12'd0;
    events_sent = trailers_seen;
    block = 0;
    upd_chain();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout_words_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // scoreboard on the output handshake
  always @(negedge clk) begin
    if (outValid && outReady) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL extra_word: got %0h expected none", outData);
      end else begin
        check("out_word", outData, exp_q.pop_front());
      end
      if (outData[39:38] == 2'b11) begin
        trailers_seen++;
        last_trailer = outData;
      end
      if (outData[39:38] == 2'b10 && outData[11:0] == 12'd0) hdr_zero++;
    end
  end

  // bus protocol monitor
  bit l1a_smp = 0, prev_read = 0, prev_load = 0;
  always @(posedge clk) l1a_smp = L1A && !reset;
  always @(negedge clk) begin
    if (swRead) check("swread_back_to_back", prev_read, 0);
    if (swBCST[11]) begin
      check("load_width", prev_load, 0);
      check("load_while_unread", swUnreadHit, 0);
    end
    if (l1a_smp || swBCST[10]) check("bcst_l1a_delay", swBCST[10], l1a_smp);
    if (dut.w_fifo_wr) check("fifo_write_when_full", (dut.w_used < DEPTH), 1);
    prev_read = swRead;
    prev_load = swBCST[11];
  end

  typedef struct {
    int          nhits;
    bit          stall;
    int          exp_left;
    int          exp_words;
    logic [39:0] exp_trailer;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #2500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int sent, w0;
    vecs[0] = '{nhits: 3,  stall: 0, exp_left: 0, exp_words: 5,  exp_trailer: {2'b11, 28'd0, 1'b0, 9'd3}};
    vecs[1] = '{nhits: 0,  stall: 0, exp_left: 0, exp_words: 2,  exp_trailer: {2'b11, 28'd0, 1'b0, 9'd0}};
    vecs[2] = '{nhits: 1,  stall: 0, exp_left: 0, exp_words: 3,  exp_trailer: {2'b11, 28'd0, 1'b0, 9'd1}};
    vecs[3] = '{nhits: 20, stall: 1, exp_left: 6, exp_words: 22, exp_trailer: {2'b11, 28'd0, 1'b0, 9'd20}};
    vecs[4] = '{nhits: 15, stall: 0, exp_left: 0, exp_words: 17, exp_trailer: {2'b11, 28'd0, 1'b0, 9'd15}};

    reset = 1'b1; L1A = 1'b0; outReady = 1'b1; L1ADelay = 9'h0A5;
    upd_chain();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bcst", swBCST, 12'h2A5);
    check("rst_outvalid", outValid, 0);
    check("rst_pending", pendingL1A, 0);
    check("rst_swread", swRead, 0);
    check("rst_overflow", l1Overflow, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bcst_after_reset", swBCST, 12'h0A5);
    L1ADelay = 9'h1C3;
    #1;
    check("bcst_delay_passthru", swBCST[8:0], 9'h1C3);
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      outReady = !vecs[v].stall;
      w0 = words_seen;
      send_l1a(vecs[v].nhits);
      if (vecs[v].stall) begin
        repeat (150) @(posedge clk);
        @(negedge clk);
        check("stall_chain_hits_left", cur_q.size(), vecs[v].exp_left);
        check("stall_outvalid", outValid, 1);
        check("stall_no_delivery", words_seen - w0, 0);
        @(posedge clk); #1;
        outReady = 1'b1;
      end
      wait_drain(2000);
      check("vec_word_count", words_seen - w0, vecs[v].exp_words);
      check("vec_trailer", last_trailer, vecs[v].exp_trailer);
      check("vec_pending_zero", pendingL1A, 0);
    end

    // L1A coinciding with load leaves the pending count unchanged
    block = 1; upd_chain();
    send_l1a(0);
    send_l1a(0);
    @(negedge clk);
    check("pending_two", pendingL1A, 2);
    @(posedge clk); #1;
    block = 0; upd_chain();
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (swBCST[11]) found = 1;
    end
    check("load_seen_for_overlap", found, 1);
    if (found) begin
      queue_event(0);
      L1A = 1'b1;
      @(posedge clk); #1;
      L1A = 1'b0;
      @(negedge clk);
      check("pending_l1a_with_load", pendingL1A, 2);
      @(posedge clk); #1;
    end
    wait_drain(500);

    // 16 back-to-back L1As with loads blocked
    block = 1; upd_chain();
    L1A = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 15) L1A = 1'b0;
      @(negedge clk);
      if (i == 14) begin
        check("pending_at_15", pendingL1A, 15);
        check("no_overflow_at_15", l1Overflow, 0);
      end
      if (i == 15) begin
        check("pending_hold_16", pendingL1A, 15);
        check("overflow_16", l1Overflow, 1);
      end
    end
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("overflow_cleared", l1Overflow, 0);
    check("pending_cleared", pendingL1A, 0);
    @(posedge clk); #1;

    // reset in the middle of a READ
    send_l1a(6);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (swRead) found = 1;
    end
    check("read_seen_for_reset", found, 1);
    do_reset();
    @(negedge clk);
    check("midrst_outvalid", outValid, 0);
    check("midrst_pending", pendingL1A, 0);
    check("midrst_swread", swRead, 0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_fifo_empty", outValid, 0);
    @(posedge clk); #1;
    send_l1a(2);
    wait_drain(500);

    // randomized events with random consumer back-pressure
    sent = 0;
    for (int cyc = 0; cyc < 4000 && sent < 40; cyc++) begin
      outReady = ($urandom_range(3) != 0);
      if ((events_sent - trailers_seen) < 10 && $urandom_range(3) == 0) begin
        send_l1a($urandom_range(8));
        sent++;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("random_events_sent", sent, 40);
    outReady = 1'b1;
    wait_drain(3000);

    // event counter wrap
    do_reset();
    hdr_zero = 0;
    sent = 0;
    for (int cyc = 0; cyc < 60000 && sent < 4097; cyc++) begin
      if ((events_sent - trailers_seen) < 12) begin
        send_l1a(0);
        sent++;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("wrap_events_sent", sent, 4097);
    wait_drain(2000);
    check("evt_wrap_zero_headers", hdr_zero, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
